arbiter_requester: RTL and testbench
====================================

ARBITER_REQUESTER -- requirements
Module: arbiter_requester

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the max cycles a client waits in REQ for grant (legal range 1-255).
REQ-002 Parameter QDEPTH, default 4, SHALL set the per-client job FIFO depth (power of 2, at least 2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  2  SHALL be a per-client one-cycle job push strobe (bit i = client i).
REQ-006 job_len0, job_len1  input  4 each  SHALL be the job length in granted cycles, sampled with start[0] and start[1] respectively.
REQ-007 grant  input  2  SHALL be the arbiter grant vector (registered, one-hot or zero).
REQ-008 request  output  2  SHALL be the registered per-client request to the arbiter.
REQ-009 busy  output  2  SHALL be high while client i is not IDLE or its FIFO is non-empty.
REQ-010 done  output  2  SHALL pulse for one cycle when client i completes a job.
REQ-011 timeout_err  output  2  SHALL be a sticky flag per client for an abandoned request.
REQ-012 ovf  output  2  SHALL be a sticky flag per client for a push dropped on a full FIFO.

Function
REQ-013 Each client SHALL own an independent FIFO, a wait counter, a length counter, and an FSM with states IDLE, REQ, XFER, GAP.
REQ-014 start[i] with FIFO not full SHALL push job_len_i; start[i] with FIFO full and no pop in the same cycle SHALL drop the push and set ovf[i].
REQ-015 A simultaneous push and pop on a full FIFO SHALL accept the push.
REQ-016 IDLE with FIFO non-empty SHALL pop the head, load the length counter (job_len 0 treated as 1), and go to REQ with request[i]=1 the next cycle.
REQ-017 REQ with grant[i]=1 sampled SHALL go to XFER; request[i] stays 1.
REQ-018 XFER SHALL decrement the length counter on each cycle grant[i]=1; a cycle with grant[i]=0 SHALL pause the count with request[i] held.
REQ-019 XFER SHALL go to GAP when the count reaches 0; the transition SHALL drop request[i] and pulse done[i] in the same cycle.
REQ-020 GAP SHALL last exactly one cycle with request[i]=0, then return to IDLE, so request never stays continuously high across two jobs.
REQ-021 A job of length N with uninterrupted grant SHALL see request[i] high for N+1 cycles (one cycle of grant latency plus N granted cycles).
REQ-022 Clients SHALL never interact; a client starved by priority SHALL remain in REQ.
REQ-023 A start strobe during REQ, XFER or GAP SHALL only queue the job.

Reset
REQ-024 When rst=0, all FSMs SHALL go to IDLE, FIFOs SHALL empty, and counters SHALL clear, independent of clk.
REQ-025 When rst=0, request, busy, done, timeout_err and ovf SHALL all be 2'b00.
REQ-026 Reset asserted mid-job SHALL discard the job without a done pulse.
REQ-027 Behaviour SHALL restart from the first posedge clk after rst returns to 1.

Configuration
REQ-028 With macro REQ_TIMEOUT_EN defined, the wait counter SHALL count REQ cycles without grant[i].
REQ-029 With REQ_TIMEOUT_EN defined, reaching TIMEOUT SHALL drop request[i], set timeout_err[i], discard the job without done, and go to GAP.
REQ-030 With REQ_TIMEOUT_EN undefined, REQ SHALL wait indefinitely, timeout_err SHALL be tied to 2'b00, and no wait counter SHALL be built.

Verification
REQ-031 Single job: start=01, job_len0=3, arbiter grants -> request[0] high 4 cycles, grant=01 3 cycles, done[0] pulses once, then one gap cycle.
REQ-032 Contention: both clients start with len 2 -> client 0 completes first, client 1 is granted after client 0's GAP, and done pulses in order 0 then 1.
REQ-033 Overflow: 5 pushes to client 1 while it is blocked in REQ, QDEPTH=4 -> ovf[1]=1 after the 5th push, and exactly 4 jobs complete later.
REQ-034 Timeout (REQ_TIMEOUT_EN, TIMEOUT=15): grant tied 00 -> request[0] drops after 15 cycles, timeout_err[0]=1, done[0] never pulses.
REQ-035 Reset mid-XFER: rst=0 during the 2nd granted cycle of a len-5 job -> all outputs 0 immediately; after release, FIFO is empty and request stays 0.
REQ-036 Grant glitch: grant[0] low for 2 cycles in XFER of a len-3 job -> request[0] held, and done[0] arrives 2 cycles later than the uninterrupted case.

Source files
------------

// File: rtl/arbiter_requester.sv
// arbiter_requester: two independent clients, each queuing jobs in a small FIFO and requesting an external arbiter.
// Optional feature macro REQ_TIMEOUT_EN: abandon a request left ungranted for TIMEOUT cycles.
module arbiter_client #(
  parameter int TIMEOUT = 15,
  parameter int QDEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] job_len_i,
  input  logic       grant_i,
  output logic       request_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_err_o,
  output logic       ovf_o
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_e;

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
    $error("QDEPTH must be a power of 2, at least 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  state_e                 state_q, state_d;
  logic [QDEPTH-1:0][3:0] mem_q;
  logic [AW-1:0]          wp_q, rp_q;
  logic [AW:0]            cnt_q, cnt_d;
  logic [3:0]             len_q, len_d, head;
  logic                   req_q, req_d, done_q, done_d, ovf_q, ovf_d;
  logic                   empty, full, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(QDEPTH));
  assign head  = mem_q[rp_q];
  assign pop   = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign push  = start_i && (!full || pop);
  assign ovf_d = ovf_q | (start_i & full & ~pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= job_len_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef REQ_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    req_d   = req_q;
    done_d  = 1'b0;
`ifdef REQ_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          len_d   = (head == 4'd0) ? 4'd1 : head;
          req_d   = 1'b1;
          state_d = REQ;
`ifdef REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      // The grant seen in REQ is already a transfer cycle, so it counts toward the length.
      REQ, XFER: begin
        if (grant_i) begin
          len_d = len_q - 4'd1;
          if (len_q == 4'd1) begin
            state_d = GAP;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = XFER;
          end
        end
`ifdef REQ_TIMEOUT_EN
        else if (state_q == REQ) begin
          if (wait_q == 8'(TIMEOUT - 1)) begin
            state_d = GAP;
            req_d   = 1'b0;
            err_d   = 1'b1;
            len_d   = '0;
          end else begin
            wait_d  = wait_q + 8'd1;
          end
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign timeout_err_o = err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  assign request_o = req_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = (state_q != IDLE) || !empty;
endmodule

module arbiter_requester #(
  parameter int TIMEOUT = 15,
  parameter int QDEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] start,
  input  logic [3:0] job_len0,
  input  logic [3:0] job_len1,
  input  logic [1:0] grant,
  output logic [1:0] request,
  output logic [1:0] busy,
  output logic [1:0] done,
  output logic [1:0] timeout_err,
  output logic [1:0] ovf
);
  localparam int NUM_CLIENTS = 2;

  logic [NUM_CLIENTS-1:0][3:0] job_len;
  assign job_len = {job_len1, job_len0};

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    arbiter_client #(
      .TIMEOUT(TIMEOUT),
      .QDEPTH (QDEPTH)
    ) u_client (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start[i]),
      .job_len_i    (job_len[i]),
      .grant_i      (grant[i]),
      .request_o    (request[i]),
      .busy_o       (busy[i]),
      .done_o       (done[i]),
      .timeout_err_o(timeout_err[i]),
      .ovf_o        (ovf[i])
    );
  end
endmodule

// File: tb/tb_arbiter_requester.sv
// Bench for arbiter_requester: directed scenarios plus random traffic against a job-level scoreboard.
module tb_arbiter_requester;
  localparam int TIMEOUT = 15;
  localparam int QDEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [3:0] job_len0, job_len1;
  logic [1:0] grant;
  logic [1:0] request, busy, done, timeout_err, ovf;

  arbiter_requester #(.TIMEOUT(TIMEOUT), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .job_len0(job_len0), .job_len1(job_len1),
    .grant(grant), .request(request), .busy(busy), .done(done),
    .timeout_err(timeout_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: queued job lengths per client, active job length, granted-cycle tally.
  int         jobq [2][$];
  int         cur_len [2];
  int         granted [2];
  logic [1:0] ovf_exp, err_exp;
  int         acc_cnt, done_cnt, tmo_cnt;
  // Behavioural registered arbiter: sticky owner, lowest index wins when free.
  int         owner;
  logic [1:0] gmask;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      jobq[i].delete();
      cur_len[i] = 0;
      granted[i] = 0;
    end
    ovf_exp = 2'b00; err_exp = 2'b00;
    acc_cnt = 0; done_cnt = 0; tmo_cnt = 0;
    owner = -1; gmask = 2'b11; grant = 2'b00;
  endtask

  task automatic tick();
    logic [1:0] rp, gp, sp, one;
    logic [3:0] l0, l1;
    rp = request; gp = grant; sp = start; l0 = job_len0; l1 = job_len1;
    @(posedge clk); #1;
    start = 2'b00;
    for (int i = 0; i < 2; i++) begin
      logic rose, fell;
      int   exp_len;
      rose = request[i] && !rp[i];
      fell = rp[i] && !request[i];
      if (gp[i] && rp[i]) granted[i]++;
      if (rose) begin
        n_assert++;
        if (jobq[i].size() == 0) begin
          n_fail++;
          $display("FAIL pop_empty c%0d: request rose, queued jobs 0, required >=1", i);
        end else begin
          cur_len[i] = jobq[i].pop_front();
          granted[i] = 0;
        end
      end
      if (sp[i]) begin
        if (jobq[i].size() < QDEPTH) begin
          jobq[i].push_back(int'(i == 0 ? l0 : l1));
          acc_cnt++;
        end else begin
          ovf_exp[i] = 1'b1;
        end
      end
      n_assert++;
      if (fell && done[i]) begin
        exp_len = (cur_len[i] == 0) ? 1 : cur_len[i];
        done_cnt++;
        if (granted[i] != exp_len) begin
          n_fail++;
          $display("FAIL job_len c%0d: granted %0d, required %0d", i, granted[i], exp_len);
        end
      end else if (fell) begin
`ifdef REQ_TIMEOUT_EN
        err_exp[i] = 1'b1;
        tmo_cnt++;
        if (timeout_err[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_drop c%0d: timeout_err %b, required 1", i, timeout_err[i]);
        end
`else
        n_fail++;
        $display("FAIL req_drop c%0d: request dropped without done, done %b required 1", i, done[i]);
`endif
      end else if (done[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL done_timing c%0d: done %b without request drop, required 0", i, done[i]);
      end
      n_assert++;
      if (ovf[i] !== ovf_exp[i]) begin
        n_fail++;
        $display("FAIL ovf c%0d: got %b, required %b", i, ovf[i], ovf_exp[i]);
      end
      n_assert++;
      if (busy[i] !== (jobq[i].size() > 0 || request[i] || fell)) begin
        n_fail++;
        $display("FAIL busy c%0d: got %b, required %b", i, busy[i],
                 (jobq[i].size() > 0 || request[i] || fell));
      end
      n_assert++;
      if (timeout_err[i] !== err_exp[i]) begin
        n_fail++;
        $display("FAIL timeout_err c%0d: got %b, required %b", i, timeout_err[i], err_exp[i]);
      end
    end
    if (!(owner >= 0 && rp[owner])) owner = rp[0] ? 0 : (rp[1] ? 1 : -1);
    one   = 2'b01;
    grant = (owner < 0) ? 2'b00 : ((one << owner) & gmask);
  endtask

  task automatic drain();
    int k = 0;
    gmask = 2'b11;
    while ((busy !== 2'b00 || request !== 2'b00) && k < 300) begin tick(); k++; end
    n_assert++;
    if (busy !== 2'b00) begin
      n_fail++;
      $display("FAIL drain: busy %b after %0d cycles, required 00", busy, k);
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 2'b00; job_len0 = '0; job_len1 = '0; grant = 2'b00;
    #1 rst = 1'b0;
    #2;
    n_assert++; if (request !== 2'b00) begin n_fail++; $display("FAIL reset_request: got %b, required 00", request); end
    n_assert++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b, required 00", busy); end
    n_assert++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b, required 00", done); end
    n_assert++; if (timeout_err !== 2'b00) begin n_fail++; $display("FAIL reset_tmo: got %b, required 00", timeout_err); end
    n_assert++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b, required 00", ovf); end
    start = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_assert++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_hold: busy %b, required 00", busy); end
    @(negedge clk);
    start = 2'b00; rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    int   nreq = 0, ng = 0, ndone = 0, kdone = -1, kfirst = -1;
    logic gap_ok = 1'b0, idle_after = 1'b0, busy_k1 = 1'b0;
    start = 2'b01; job_len0 = 4'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) busy_k1 = busy[0];
      if (request[0]) begin nreq++; if (kfirst < 0) kfirst = k; end
      if (request[0] && grant[0]) ng++;
      if (done[0]) begin ndone++; kdone = k; gap_ok = !request[0] && busy[0]; end
      if (k == 7) idle_after = !busy[0];
    end
    n_assert++; if (busy_k1 !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %b, required 1", busy_k1); end
    n_assert++; if (kfirst != 2) begin n_fail++; $display("FAIL single_req_start: cycle %0d, required 2", kfirst); end
    n_assert++; if (nreq != 4) begin n_fail++; $display("FAIL single_req_len: %0d cycles, required 4", nreq); end
    n_assert++; if (ng != 3) begin n_fail++; $display("FAIL single_grant_len: %0d cycles, required 3", ng); end
    n_assert++; if (ndone != 1) begin n_fail++; $display("FAIL single_done_cnt: %0d, required 1", ndone); end
    n_assert++; if (kdone != 6) begin n_fail++; $display("FAIL single_done_cycle: %0d, required 6", kdone); end
    n_assert++; if (gap_ok !== 1'b1) begin n_fail++; $display("FAIL single_gap: got %b, required 1", gap_ok); end
    n_assert++; if (idle_after !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b, required 1", idle_after); end
    drain();
  endtask

  task automatic test_contention();
    int kd0 = -1, kd1 = -1, kg1 = -1;
    start = 2'b11; job_len0 = 4'd2; job_len1 = 4'd2;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done[0] && kd0 < 0) kd0 = k;
      if (done[1] && kd1 < 0) kd1 = k;
      if (grant[1] && request[1] && kg1 < 0) kg1 = k;
    end
    n_assert++; if (kd0 != 5) begin n_fail++; $display("FAIL cont_done0: cycle %0d, required 5", kd0); end
    n_assert++; if (kg1 != 6) begin n_fail++; $display("FAIL cont_grant1: cycle %0d, required 6", kg1); end
    n_assert++; if (kd1 != 8) begin n_fail++; $display("FAIL cont_done1: cycle %0d, required 8", kd1); end
    drain();
  endtask

  task automatic test_glitch();
    int nreq = 0, ng = 0, kdone = -1;
    start = 2'b01; job_len0 = 4'd3;
    for (int k = 1; k <= 12; k++) begin
      gmask = (k == 4 || k == 5) ? 2'b00 : 2'b11;
      tick();
      if (request[0]) nreq++;
      if (request[0] && grant[0]) ng++;
      if (done[0] && kdone < 0) kdone = k;
    end
    n_assert++; if (nreq != 6) begin n_fail++; $display("FAIL glitch_req_len: %0d cycles, required 6", nreq); end
    n_assert++; if (ng != 3) begin n_fail++; $display("FAIL glitch_grant_len: %0d cycles, required 3", ng); end
    n_assert++; if (kdone != 8) begin n_fail++; $display("FAIL glitch_done_cycle: %0d, required 8", kdone); end
    drain();
  endtask

  task automatic test_overflow();
    int nd = 0, k = 0;
    gmask = 2'b00;
    start = 2'b10; job_len1 = 4'd1;
    tick(); tick(); tick();
    for (int n = 1; n <= 5; n++) begin
      start = 2'b10; job_len1 = 4'(n + 1);
      tick();
      if (n == 4) begin
        n_assert++; if (ovf[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, required 0", ovf[1]); end
      end
    end
    n_assert++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_set: got %b, required 10", ovf); end
    gmask = 2'b11;
    while (busy[1] !== 1'b0 && k < 300) begin tick(); if (done[1]) nd++; k++; end
    n_assert++; if (nd - 1 != 4) begin n_fail++; $display("FAIL ovf_jobs: %0d queued jobs done, required 4", nd - 1); end
    n_assert++; if (ovf[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", ovf[1]); end
    drain();
  endtask

`ifdef REQ_TIMEOUT_EN
  task automatic test_timeout();
    int nreq = 0, nd = 0;
    gmask = 2'b00;
    start = 2'b01; job_len0 = 4'd4;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (request[0]) nreq++;
      if (done[0]) nd++;
    end
    n_assert++; if (nreq != TIMEOUT) begin n_fail++; $display("FAIL tmo_req_len: %0d cycles, required %0d", nreq, TIMEOUT); end
    n_assert++; if (timeout_err[0] !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b, required 1", timeout_err[0]); end
    n_assert++; if (nd != 0) begin n_fail++; $display("FAIL tmo_done: %0d pulses, required 0", nd); end
    drain();
  endtask
`else
  task automatic test_starve();
    int nreq = 0, nd = 0;
    gmask = 2'b00;
    start = 2'b01; job_len0 = 4'd4;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (request[0]) nreq++;
      if (done[0]) nd++;
    end
    n_assert++; if (nreq != 39) begin n_fail++; $display("FAIL starve_req: %0d cycles high, required 39", nreq); end
    n_assert++; if (nd != 0) begin n_fail++; $display("FAIL starve_done: %0d pulses, required 0", nd); end
    drain();
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      start    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      job_len0 = 4'($urandom);
      job_len1 = 4'($urandom);
      gmask    = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      tick();
    end
    drain();
    n_assert++;
    if (acc_cnt != done_cnt + tmo_cnt) begin
      n_fail++;
      $display("FAIL rand_jobs: %0d finished, required %0d accepted", done_cnt + tmo_cnt, acc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    start = 2'b01; job_len0 = 4'd5;
    tick();
    start = 2'b01; job_len0 = 4'd7;
    tick(); tick(); tick();
    n_assert++;
    if ((request[0] && grant[0]) !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: req&grant %b, required 1", request[0] && grant[0]);
    end
    #1 rst = 1'b0;
    #1;
    n_assert++;
    if ({request, busy, done, timeout_err, ovf} !== 10'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: req %b busy %b done %b tmo %b ovf %b, required all 00",
               request, busy, done, timeout_err, ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_assert++;
      if ({request, busy, done} !== 6'd0) begin
        n_fail++;
        $display("FAIL rmid_after c%0d: req %b busy %b done %b, required 00", k, request, busy, done);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_glitch();
    test_overflow();
`ifdef REQ_TIMEOUT_EN
    test_timeout();
`else
    test_starve();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
